// File: rtl/tone_frame_gen.sv
// Burst generator of FRAMES x 16-sample cosine-tone frames on a data/data_valid stream.
// Define NOISE_EN to add saturated LFSR dither (-8..7) to every sample.
module tone_frame_gen #(
  parameter int unsigned FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  freq,
  input  logic [7:0]  amp,
  input  logic        hold,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  state_e      state_q, state_d;
  logic        go_q, go_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  freq_q, freq_d;
  logic [7:0]  amp_q, amp_d;
  logic [3:0]  phase_q, phase_d;
  logic [3:0]  n_q, n_d;
  logic [7:0]  f_q, f_d;

  logic signed [15:0] lut_val;
  logic signed [24:0] prod;
  logic signed [15:0] scaled;
  logic [15:0]        sample;
  logic               accept;

  function automatic logic signed [15:0] cos_lut(input logic [3:0] k);
    logic signed [15:0] v;
    unique case (k)
      4'd0:    v = 16'sd16384;
      4'd1:    v = 16'sd15137;
      4'd2:    v = 16'sd11585;
      4'd3:    v = 16'sd6270;
      4'd4:    v = 16'sd0;
      4'd5:    v = -16'sd6270;
      4'd6:    v = -16'sd11585;
      4'd7:    v = -16'sd15137;
      4'd8:    v = -16'sd16384;
      4'd9:    v = -16'sd15137;
      4'd10:   v = -16'sd11585;
      4'd11:   v = -16'sd6270;
      4'd12:   v = 16'sd0;
      4'd13:   v = 16'sd6270;
      4'd14:   v = 16'sd11585;
      default: v = 16'sd15137;
    endcase
    return v;
  endfunction

  // amp is zero-extended so the product stays signed; >>> 8 floors
  always_comb begin
    lut_val = cos_lut(phase_q);
    prod    = lut_val * $signed({1'b0, amp_q});
    scaled  = 16'(prod >>> 8);
  end

  assign accept = start & ~busy_q & ~go_q;

`ifdef NOISE_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic               lfsr_fb;
  logic signed [15:0] noise;
  logic signed [16:0] sum;

  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    noise   = {{12{lfsr_q[3]}}, lfsr_q[3:0]};
    sum     = {scaled[15], scaled} + {noise[15], noise};
    sample  = sum[15:0];
    if (sum[16] != sum[15]) begin
      sample = sum[16] ? 16'h8000 : 16'h7fff;
    end
    lfsr_d = lfsr_q;
    if (state_q == IDLE && accept) begin
      lfsr_d = 16'hace1;
    end else if (state_q == RUN && !hold) begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hace1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  always_comb begin
    sample = scaled;
  end
`endif

  always_comb begin
    state_d = state_q;
    go_d    = 1'b0;
    busy_d  = busy_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    data_d  = data_q;
    freq_d  = freq_q;
    amp_d   = amp_q;
    phase_d = phase_q;
    n_d     = n_q;
    f_d     = f_q;
    unique case (state_q)
      IDLE: begin
        if (go_q) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
          if (accept) begin
            go_d    = 1'b1;
            freq_d  = freq;
            amp_d   = amp;
            phase_d = 4'd0;
            n_d     = 4'd0;
            f_d     = 8'd0;
          end
        end
      end
      RUN: begin
        if (!hold) begin
          valid_d = 1'b1;
          data_d  = sample;
          phase_d = phase_q + freq_q;
          n_d     = n_q + 4'd1;
          if (n_q == 4'd15) begin
            f_d = f_q + 8'd1;
            if (f_q == 8'(FRAMES - 1)) begin
              state_d = FIN;
            end
          end
        end
      end
      FIN: begin
        // busy stays high through the done cycle, drops one edge later
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      data_q  <= 16'h0000;
      freq_q  <= 4'd0;
      amp_q   <= 8'd0;
      phase_q <= 4'd0;
      n_q     <= 4'd0;
      f_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      data_q  <= data_d;
      freq_q  <= freq_d;
      amp_q   <= amp_d;
      phase_q <= phase_d;
      n_q     <= n_d;
      f_q     <= f_d;
    end
  end

  assign busy       = busy_q;
  assign data_valid = valid_q;
  assign data       = data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_tone_frame_gen.sv
// Randomized bench for tone_frame_gen: FRAMES=1 and FRAMES=2 instances
// share stimulus and are compared every cycle to a burst-level model.
module tb_tone_frame_gen;

  localparam int F2 = 2;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic [3:0]  freq;
  logic [7:0]  amp;
  logic        busy_o  [2];
  logic        valid_o [2];
  logic        done_o  [2];
  logic [15:0] data_o  [2];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tone_frame_gen #(.FRAMES(1)) u_f1 (
    .clk(clk), .rst(rst), .start(start), .freq(freq), .amp(amp),
    .hold(hold), .busy(busy_o[0]), .data_valid(valid_o[0]),
    .data(data_o[0]), .done(done_o[0])
  );

  tone_frame_gen #(.FRAMES(F2)) u_f2 (
    .clk(clk), .rst(rst), .start(start), .freq(freq), .amp(amp),
    .hold(hold), .busy(busy_o[1]), .data_valid(valid_o[1]),
    .data(data_o[1]), .done(done_o[1])
  );

  int lut_tab [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                       -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};

  int          nfr    [2] = '{16, F2 * 16};
  int          m_busy [2] = '{0, 0};
  int          m_valid[2] = '{0, 0};
  int          m_done [2] = '{0, 0};
  int          m_data [2] = '{0, 0};
  bit          m_go   [2] = '{0, 0};
  bit          m_run  [2] = '{0, 0};
  bit          m_fin  [2] = '{0, 0};
  bit          m_tail [2] = '{0, 0};
  int          m_e    [2] = '{0, 0};
  int          m_f    [2] = '{0, 0};
  int          m_a    [2] = '{0, 0};
  logic [15:0] m_lf   [2] = '{16'hace1, 16'hace1};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int expect_sample(input int fr, input int am,
                                       input int idx, input logic [15:0] l);
    int p, q, d;
    p = lut_tab[(idx * fr) % 16] * am;
    q = p / 256;
    if (p < 0 && p % 256 != 0) q = q - 1;
`ifdef NOISE_EN
    d = int'(l[3:0]);
    if (d >= 8) d = d - 16;
    q = q + d;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`else
    d = int'(l[0]);
    d = d * 0;
    q = q + d;
`endif
    return q;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_busy[k] = 0; m_valid[k] = 0; m_done[k] = 0; m_data[k] = 0;
        m_go[k] = 0; m_run[k] = 0; m_fin[k] = 0; m_tail[k] = 0;
        m_e[k] = 0;
      end else begin
        m_done[k] = 0;
        m_valid[k] = 0;
        if (m_fin[k]) begin
          m_done[k] = 1; m_fin[k] = 0; m_tail[k] = 1;
        end else if (m_tail[k]) begin
          m_busy[k] = 0; m_tail[k] = 0;
        end else if (m_run[k]) begin
          if (!hold) begin
            m_valid[k] = 1;
            m_data[k] = expect_sample(m_f[k], m_a[k], m_e[k] % 16, m_lf[k]);
            m_lf[k] = lfsr_next(m_lf[k]);
            m_e[k]++;
            if (m_e[k] == nfr[k]) begin
              m_run[k] = 0; m_fin[k] = 1;
            end
          end
        end else if (m_go[k]) begin
          m_go[k] = 0; m_run[k] = 1; m_busy[k] = 1;
        end else if (start) begin
          m_go[k] = 1; m_f[k] = int'(freq); m_a[k] = int'(amp);
          m_e[k] = 0; m_lf[k] = 16'hace1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_busy[k]));
      check($sformatf("valid%0d", k), 32'(valid_o[k]), 32'(m_valid[k]));
      check($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
      check($sformatf("data%0d", k), 32'($signed(data_o[k])), m_data[k]);
    end
  endtask

  task automatic burst(input int fr, input int am, input int hold_pct,
                       input bit poke, input bit kill);
    int cyc;
    freq = 4'(fr);
    amp = 8'(am);
    start = 1'b1;
    step();
    start = 1'b0;
    freq = 4'($urandom);
    amp = 8'($urandom);
    cyc = 0;
    while ((m_busy[0] || m_go[0] || m_busy[1] || m_go[1]) && cyc < 600) begin
      hold = ($urandom_range(99) < hold_pct);
      start = (poke && cyc == 6);
      if (poke && cyc == 6) freq = 4'd3;
      rst = (kill && cyc == 12);
      step();
      cyc++;
    end
    hold = 1'b0;
    start = 1'b0;
    rst = 1'b0;
    if (cyc >= 600) check("timeout", 32'(cyc), 32'd0);
    step();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    freq = 4'd0;
    amp = 8'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    burst(0, 255, 0, 0, 0);
    burst(4, 128, 0, 0, 0);
    burst(1, 255, 0, 0, 0);
    burst(0, 255, 0, 0, 0);
    burst(5, 200, 30, 0, 0);
    burst(7, 99, 0, 1, 0);
    burst(2, 180, 0, 0, 1);
    burst(9, 0, 20, 0, 0);
    for (int i = 0; i < 8; i++) begin
      burst(int'($urandom_range(15)), int'($urandom_range(255)),
            int'($urandom_range(40)), 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tone_frame_gen.md
Name: tone_frame_gen

Overview:
Stimulus transmitter for the FFT analysis block. On a start request it synthesizes FRAMES back-to-back 16-sample frames of a single cosine tone, at bin index freq and scaled by amp, and streams them as a signed 16-bit sample stream with data_valid. This is the producing end of the data/data_valid interface that the FFT analyzer consumes, so a correct analyzer reports the programmed freq.

Parameters:
FRAMES, 1, number of 16-sample frames emitted per start; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request a burst; sampled only while busy=0
freq  input  4  tone bin index 0..15; captured on accepted start
amp  input  8  unsigned amplitude scale 0..255; captured on accepted start
hold  input  1  stall; while high in RUN, no sample is emitted
busy  output  1  high while a burst is in progress
data_valid  output  1  sample qualifier
data  output  16  signed sample, two's complement
done  output  1  one-cycle pulse after the last sample of a burst

Behaviour:
- Reset values: busy=0, data_valid=0, data=16'h0000, done=0; FSM=IDLE; phase, sample and frame counters=0.
- rst asserted mid-burst: next edge returns all state and outputs to the reset values; the burst is abandoned and no done pulse is issued.
- FSM states IDLE, RUN, FIN:
  - IDLE: start=1 at edge t -> latch freq/amp, phase=0, n=0, f=0 -> RUN; busy=1 from t+1.
  - RUN, hold=0: each edge registers one sample (data_valid=1), phase+=freq (mod 16), n+=1 (mod 16); when n wraps, f+=1. The edge that registers sample n=15 of frame FRAMES-1 -> FIN.
  - RUN, hold=1: data_valid=0, data keeps its last value, all counters frozen.
  - FIN: data_valid=0, done=1, busy=1 for exactly one cycle -> IDLE. busy=0 on the following cycle.
- start while busy=1 is ignored; freq/amp changes after capture have no effect.
- Latency: start at edge t -> first valid sample at edge t+2 (t+1 enters RUN); a burst with no hold occupies FRAMES*16 consecutive data_valid cycles.
- Sample arithmetic: data = (LUT[phase] * amp) >>> 8. LUT is signed 16-bit, amp is zero-extended, the product is 25-bit signed, and the shift is arithmetic (floor). The result never exceeds 16 bits.
- LUT (Q1.14 cos(2*pi*k/16)), k=0..15: 16384, 15137, 11585, 6270, 0, -6270, -11585, -15137, -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137.
- Phase at sample n is (n*freq) mod 16, so every frame is identical and starts at phase 0.
- freq=0 gives constant DC. amp=0 gives all-zero samples that are still flagged valid.
- data_valid is never high in IDLE or FIN.

Optional Feature:
NOISE_EN
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset and on each accepted start) advances once per emitted sample. Its low 4 bits, sign-extended (-8..7), are added to the scaled sample. The sum saturates to [-32768, 32767].
- Undefined: no LFSR logic; data is exactly the scaled LUT value.

Test Plan:
- freq=0, amp=255, FRAMES=1, start pulse -> 16 consecutive valid samples all 16320 (first at start edge+2); done one cycle later; busy falls the cycle after done.
- freq=4, amp=128 -> sample pattern 8192, 0, -8192, 0 repeated 4 times.
- freq=1, amp=255 -> sample 1 = 15077 and sample 7 = -15078 (floor rounding check); sample 8 = -16320.
- FRAMES=2, hold high for 3 cycles mid-frame -> 32 valid samples total; data frozen with data_valid=0 during hold; sequence resumes without skip; done only after sample 31.
- start re-pulsed with freq=3 mid-burst -> ignored (burst continues at the original freq). Then rst mid-burst -> next cycle busy=0, data_valid=0, data=0, no done pulse.
- NOISE_EN defined, freq=0, amp=255 -> every sample lies within 16320-8..16320+7 and matches the LFSR model; the same sequence repeats on a second start.
